// File: rtl/bist_pkg.sv
// Shared types and helpers for the flopr self-test engine: FSM states,
// default feedback polynomials and the Galois shift step used by LFSR and MISR.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned ERR_W  = 16;
   localparam logic [63:0] POLY64 = 64'hD800_0000_0000_0000;

   // Default polynomial per register width; unlisted widths fall back to x^n+1.
   function automatic logic [63:0] poly_for(input int unsigned n);
      logic [63:0] p;
      p = 64'h1;
      case (n)
         8:       p = 64'h0000_0000_0000_00B8;
         16:      p = 64'h0000_0000_0000_B400;
         32:      p = 64'h0000_0000_A300_0000;
         64:      p = POLY64;
         default: p = 64'h1;
      endcase
      return p;
   endfunction

   // One Galois step on the low n bits of v: shift left, fold msb back through poly.
   function automatic logic [63:0] lfsr_next(input logic [63:0] v,
                                             input logic [63:0] poly,
                                             input int unsigned n);
      logic [63:0] mask;
      logic [63:0] r;
      mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
      r    = (v << 1) & mask;
      if (v[6'(n - 1)]) begin
         r = r ^ (poly & mask);
      end
      return r;
   endfunction

endpackage

// File: rtl/galois_shift.sv
// Combinational Galois shift step with an extra XOR input; add_i is zero for
// a plain LFSR and carries the observed response when used as a MISR.
module galois_shift
   import bist_pkg::*;
#(
   parameter int unsigned     N    = 64,
   parameter logic [N-1:0]    POLY = N'(poly_for(N))
) (
   input  logic [N-1:0] v_i,
   input  logic [N-1:0] add_i,
   output logic [N-1:0] nxt_c
);

   assign nxt_c = N'(lfsr_next(64'(v_i), 64'(POLY), N)) ^ add_i;

endmodule

// File: rtl/flopr_bist.sv
// Self-test engine for the datapath reset register: drives LFSR patterns with
// periodic resets, checks q against a one-register model and compacts q in a MISR.
module flopr_bist
   import bist_pkg::*;
#(
   parameter int unsigned  N         = 64,
   parameter int unsigned  CNT_TESTS = 1000,
   parameter logic [N-1:0] SEED      = N'(1),
   parameter logic [N-1:0] POLY      = N'(poly_for(N))
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [N-1:0]     golden,
   output logic             dut_reset,
   output logic [N-1:0]     dut_d,
   input  logic [N-1:0]     dut_q,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [N-1:0]     signature
);

   localparam int unsigned      CNT_W    = (CNT_TESTS > 1) ? $clog2(CNT_TESTS) : 1;
   localparam int unsigned      IDX_W    = (CNT_W < 4) ? 4 : CNT_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CNT_TESTS - 1);
   localparam logic [N-1:0]     SEED_EFF = (SEED == '0) ? N'(1) : SEED;
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t             state_q,     state_d;
   logic [IDX_W-1:0]   idx_q,       idx_d;
   logic [N-1:0]       lfsr_q,      lfsr_d;
   logic               dut_reset_q, dut_reset_d;
   logic [N-1:0]       dut_d_q,     dut_d_d;
   logic [N-1:0]       exp_q,       exp_d;
   logic               chk_vld_q,   chk_vld_d;
   logic [ERR_W-1:0]   err_q,       err_d;
   logic [N-1:0]       sig_q,       sig_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic               pass_q,      pass_d;
   logic [N-1:0]       lfsr_nxt_c;
   logic [N-1:0]       sig_nxt_c;

   galois_shift #(.N(N), .POLY(POLY)) u_lfsr (
      .v_i   (lfsr_q),
      .add_i ('0),
      .nxt_c (lfsr_nxt_c)
   );

   galois_shift #(.N(N), .POLY(POLY)) u_misr (
      .v_i   (sig_q),
      .add_i (dut_q),
      .nxt_c (sig_nxt_c)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      lfsr_d      = lfsr_q;
      dut_reset_d = 1'b1;
      dut_d_d     = '0;
      chk_vld_d   = (state_q == RUN);
      exp_d       = exp_q;
      err_d       = err_q;
      sig_d       = sig_q;
      pass_d      = pass_q;

      // Model of the register under test for the pattern currently on the pins.
      if (state_q == RUN) begin
         exp_d = dut_reset_q ? '0 : dut_d_q;
      end

      // X on dut_q must count as a mismatch, hence the case-inequality.
      if (chk_vld_q) begin
         if ((dut_q !== exp_q) && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
         end
         sig_d = sig_nxt_c;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = RUN;
               idx_d       = '0;
               lfsr_d      = SEED_EFF;
               dut_d_d     = SEED_EFF;
               dut_reset_d = 1'b1;
               err_d       = '0;
               sig_d       = '0;
               pass_d      = 1'b0;
            end
         end
         RUN: begin
            if (idx_q == LAST_IDX) begin
               state_d = DRAIN;
            end else begin
               idx_d       = idx_q + IDX_W'(1);
               lfsr_d      = lfsr_nxt_c;
               dut_d_d     = lfsr_nxt_c;
               dut_reset_d = (idx_d[3:0] == 4'hF);
            end
         end
         DRAIN: begin
            state_d = DONE;
            pass_d  = (err_d == '0) && (sig_d == golden);
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         lfsr_q      <= SEED_EFF;
         dut_reset_q <= 1'b1;
         dut_d_q     <= '0;
         exp_q       <= '0;
         chk_vld_q   <= 1'b0;
         err_q       <= '0;
         sig_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         lfsr_q      <= lfsr_d;
         dut_reset_q <= dut_reset_d;
         dut_d_q     <= dut_d_d;
         exp_q       <= exp_d;
         chk_vld_q   <= chk_vld_d;
         err_q       <= err_d;
         sig_q       <= sig_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   assign dut_reset = dut_reset_q;
   assign dut_d     = dut_d_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_cnt   = err_q;
   assign signature = sig_q;

endmodule

// File: tb/tb_flopr_bist.sv
// Scoreboard bench: two engines (8-bit/4 patterns and 64-bit/1000 patterns),
// each wired to a behavioural synchronous-reset register.
module tb_flopr_bist;

   localparam int CB = 1000;

   typedef struct packed {
      logic        rst;
      logic [63:0] d;
   } pat_t;

   typedef struct packed {
      logic [15:0] err;
      logic        pass;
      logic [63:0] sig;
   } res_t;

   logic        clk;
   logic        reset;
   logic        start_a, start_b;
   logic [7:0]  golden_a;
   logic [63:0] golden_b;
   logic        inj_a;

   logic        dut_reset_a, busy_a, done_a, pass_a;
   logic [7:0]  dut_d_a, dut_q_a, q_a, sig_a;
   logic [15:0] err_a;

   logic        dut_reset_b, busy_b, done_b, pass_b;
   logic [63:0] dut_d_b, dut_q_b, q_b, sig_b;
   logic [15:0] err_b;

   pat_t pat_qa[$], pat_qb[$];
   res_t res_qa[$], res_qb[$];
   pat_t ea, eb;
   res_t ra, rb;
   logic done_a_d = 1'b0;
   logic done_b_d = 1'b0;
   int   n_vec = 0;
   int   n_mis = 0;

   flopr_bist #(.N(8), .CNT_TESTS(4), .SEED(8'h01), .POLY(8'hB8)) u_a (
      .clk(clk), .reset(reset), .start(start_a), .golden(golden_a),
      .dut_reset(dut_reset_a), .dut_d(dut_d_a), .dut_q(dut_q_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .signature(sig_a)
   );

   flopr_bist u_b (
      .clk(clk), .reset(reset), .start(start_b), .golden(golden_b),
      .dut_reset(dut_reset_b), .dut_d(dut_d_b), .dut_q(dut_q_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .signature(sig_b)
   );

   // Registers under test (synchronous reset flops).
   always @(posedge clk) q_a <= dut_reset_a ? 8'h00 : dut_d_a;
   always @(posedge clk) q_b <= dut_reset_b ? 64'h0 : dut_d_b;

   // Fault: q bit 0 stuck at 1 while the register holds pattern 2 (value 04).
   assign dut_q_a = q_a | {7'd0, inj_a && (q_a == 8'h04)};
   assign dut_q_b = q_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm);
      n_vec++;
      n_mis++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   function automatic logic [63:0] sh64(input logic [63:0] v);
      return {v[62:0], 1'b0} ^ (v[63] ? 64'hD800_0000_0000_0000 : 64'h0);
   endfunction

   // Monitor A: per-cycle pins while busy, final result when done rises.
   always @(negedge clk) begin
      if (busy_a === 1'b1) begin
         if (pat_qa.size() == 0) flag("a_busy_too_long");
         else begin
            ea = pat_qa.pop_front();
            chk("a_dut_reset", 64'(dut_reset_a), 64'(ea.rst));
            chk("a_dut_d", 64'(dut_d_a), ea.d);
         end
      end
      if (done_a === 1'b1 && !done_a_d) begin
         if (res_qa.size() == 0) flag("a_done_unexpected");
         else begin
            ra = res_qa.pop_front();
            chk("a_err_cnt", 64'(err_a), 64'(ra.err));
            chk("a_pass", 64'(pass_a), 64'(ra.pass));
            chk("a_signature", 64'(sig_a), ra.sig);
         end
      end
      done_a_d = (done_a === 1'b1);
   end

   always @(negedge clk) begin
      if (busy_b === 1'b1) begin
         if (pat_qb.size() == 0) flag("b_busy_too_long");
         else begin
            eb = pat_qb.pop_front();
            chk("b_dut_reset", 64'(dut_reset_b), 64'(eb.rst));
            chk("b_dut_d", dut_d_b, eb.d);
         end
      end
      if (done_b === 1'b1 && !done_b_d) begin
         if (res_qb.size() == 0) flag("b_done_unexpected");
         else begin
            rb = res_qb.pop_front();
            chk("b_err_cnt", 64'(err_b), 64'(rb.err));
            chk("b_pass", 64'(pass_b), 64'(rb.pass));
            chk("b_signature", sig_b, rb.sig);
         end
      end
      done_b_d = (done_b === 1'b1);
   end

   // Expected pins for 8-bit run: 01,02,04,08 then the drain cycle.
   task automatic push_run_a(input logic [15:0] err, input logic pass, input logic [7:0] sig);
      pat_t p;
      res_t r;
      p = '{rst: 1'b1, d: 64'h01}; pat_qa.push_back(p);
      p = '{rst: 1'b0, d: 64'h02}; pat_qa.push_back(p);
      p = '{rst: 1'b0, d: 64'h04}; pat_qa.push_back(p);
      p = '{rst: 1'b0, d: 64'h08}; pat_qa.push_back(p);
      p = '{rst: 1'b1, d: 64'h00}; pat_qa.push_back(p);
      r = '{err: err, pass: pass, sig: 64'(sig)};
      res_qa.push_back(r);
   endtask

   task automatic push_run_b(output logic [63:0] sig);
      logic [63:0] l;
      pat_t        p;
      res_t        r;
      l   = 64'h1;
      sig = 64'h0;
      for (int k = 0; k < CB; k++) begin
         p.rst = (k == 0) || ((k % 16) == 15);
         p.d   = l;
         pat_qb.push_back(p);
         sig = sh64(sig) ^ (p.rst ? 64'h0 : l);
         l   = sh64(l);
      end
      p = '{rst: 1'b1, d: 64'h0};
      pat_qb.push_back(p);
      r = '{err: 16'h0, pass: 1'b1, sig: sig};
      res_qb.push_back(r);
   endtask

   task automatic idle_chk_a(input string tag);
      chk({tag, "_a_busy"}, 64'(busy_a), 64'd0);
      chk({tag, "_a_done"}, 64'(done_a), 64'd0);
      chk({tag, "_a_pass"}, 64'(pass_a), 64'd0);
      chk({tag, "_a_dut_reset"}, 64'(dut_reset_a), 64'd1);
      chk({tag, "_a_dut_d"}, 64'(dut_d_a), 64'd0);
      chk({tag, "_a_err"}, 64'(err_a), 64'd0);
      chk({tag, "_a_sig"}, 64'(sig_a), 64'd0);
   endtask

   task automatic idle_chk_b(input string tag);
      chk({tag, "_b_busy"}, 64'(busy_b), 64'd0);
      chk({tag, "_b_done"}, 64'(done_b), 64'd0);
      chk({tag, "_b_dut_reset"}, 64'(dut_reset_b), 64'd1);
      chk({tag, "_b_dut_d"}, dut_d_b, 64'd0);
      chk({tag, "_b_err"}, 64'(err_b), 64'd0);
   endtask

   task automatic pulse_a(input int cycles);
      @(posedge clk); #1 start_a = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 start_a = 1'b0;
   endtask

   task automatic pulse_b;
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
   endtask

   task automatic wait_done_a(input int max);
      int n;
      n = 0;
      while (done_a !== 1'b1 && n <= max) begin
         @(negedge clk);
         n++;
      end
      if (done_a !== 1'b1) flag("a_done_timeout");
      @(negedge clk);
      chk("a_pat_queue_empty", 64'(pat_qa.size()), 64'd0);
      chk("a_res_queue_empty", 64'(res_qa.size()), 64'd0);
      chk("a_done_hold", 64'(done_a), 64'd1);
      chk("a_done_dut_reset", 64'(dut_reset_a), 64'd1);
   endtask

   task automatic wait_done_b(input int max);
      int n;
      n = 0;
      while (done_b !== 1'b1 && n <= max) begin
         @(negedge clk);
         n++;
      end
      if (done_b !== 1'b1) flag("b_done_timeout");
      @(negedge clk);
      chk("b_pat_queue_empty", 64'(pat_qb.size()), 64'd0);
      chk("b_res_queue_empty", 64'(res_qb.size()), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      n_mis++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] sig_model;
      bit          hit;
      reset    = 1'b0;
      start_a  = 1'b0;
      start_b  = 1'b0;
      inj_a    = 1'b0;
      golden_a = 8'h00;
      golden_b = 64'h0;

      // Reset for 3 cycles, then idle with no start.
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) begin
         @(negedge clk);
         idle_chk_a("idle");
         idle_chk_b("idle");
      end

      // Run with matching golden; start held into RUN must be ignored.
      push_run_a(16'h0, 1'b1, 8'h08);
      golden_a = 8'h08;
      pulse_a(3);
      wait_done_a(20);

      // Restart from DONE with a wrong golden.
      push_run_a(16'h0, 1'b0, 8'h08);
      golden_a = 8'h09;
      pulse_a(1);
      wait_done_a(20);

      // Stuck-at-1 on q[0] while pattern 2 is held.
      inj_a = 1'b1;
      push_run_a(16'h1, 1'b0, 8'h0A);
      golden_a = 8'h08;
      pulse_a(1);
      wait_done_a(20);
      inj_a = 1'b0;

      // Abort with reset while pattern 2 is being driven.
      push_run_a(16'h0, 1'b1, 8'h08);
      pulse_a(1);
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         if (busy_a === 1'b1 && dut_d_a == 8'h04) hit = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!hit) flag("a_idx2_not_seen");
      reset = 1'b0;
      @(posedge clk); #1;
      idle_chk_a("abort");
      idle_chk_b("abort");
      pat_qa.delete();
      res_qa.delete();

      // Start coincident with reset is ignored.
      start_a = 1'b1;
      @(posedge clk); #1;
      reset   = 1'b1;
      start_a = 1'b0;
      chk("rst_start_busy", 64'(busy_a), 64'd0);
      @(posedge clk); #1;
      idle_chk_a("rst_start");

      // Fresh run after abort repeats the basic run exactly.
      push_run_a(16'h0, 1'b1, 8'h08);
      golden_a = 8'h08;
      pulse_a(1);
      wait_done_a(20);

      // 64-bit, 1000 patterns, twice back-to-back.
      for (int run = 0; run < 2; run++) begin
         push_run_b(sig_model);
         golden_b = sig_model;
         pulse_b();
         wait_done_b(CB + 50);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
